// File: rtl/tt_um_prog_seq_det_if.sv
// Tiny Tapeout user-macro pin bundle for the programmable sequence detector.
// The master side drives the inputs; the detector connects through the slave side.
interface tt_um_prog_seq_det_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_prog_seq_det.sv
// Programmable serial sequence detector with run-time loadable pattern,
// overlap/non-overlap matching and a hex match count on the 7-segment output.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_DETECT | ui_in[2] = 0: strobe rises shift bits in and are matched
// ST_LOAD   | ui_in[2] = 1: pattern/len/overlap latched, history cleared
module tt_um_prog_seq_det #(
    parameter int          MAX_LEN       = 8,
    parameter logic [7:0]  RESET_PATTERN = 8'b0000_1011,
    parameter int          RESET_LEN     = 4,
    parameter bit          RESET_OVERLAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_um_prog_seq_det_if.slave   bus
);

    localparam logic [0:0] ST_DETECT = 1'b0;
    localparam logic [0:0] ST_LOAD   = 1'b1;

    logic [0:0]         mode;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] h_next;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN:0]   h_ext;
    logic [3:0]         len;
    logic [3:0]         len_req;
    logic [3:0]         fill;
    logic [3:0]         f_next;
    logic [3:0]         count;
    logic               overlap;
    logic               det;
    logic               strobe_q;
    logic               accept;
    logic               match;
    logic [6:0]         seg;
    logic               unused_ok;

    assign mode      = bus.ui_in[2];
    assign accept    = bus.ui_in[1] & ~strobe_q;
    assign unused_ok = &{1'b0, bus.ena, bus.uio_in};

    always_comb begin
        h_ext  = {hist, bus.ui_in[0]};
        h_next = h_ext[MAX_LEN-1:0];
        f_next = (fill >= 4'(MAX_LEN)) ? 4'(MAX_LEN) : fill + 4'd1;
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (4'(i) < len);
        end
        // A match needs at least len bits seen since the last clear point.
        match   = (f_next >= len) && ((h_next & mask) == (pattern & mask));
        len_req = {1'b0, bus.ui_in[6:4]} + 4'd1;
        if (len_req > 4'(MAX_LEN)) begin
            len_req = 4'(MAX_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern  <= RESET_PATTERN[MAX_LEN-1:0];
            len      <= 4'(RESET_LEN);
            overlap  <= RESET_OVERLAP;
            hist     <= '0;
            fill     <= '0;
            count    <= '0;
            det      <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= bus.ui_in[1];
            if (mode == ST_LOAD) begin
                pattern <= bus.uio_in[MAX_LEN-1:0];
                len     <= len_req;
                overlap <= bus.ui_in[3];
                hist    <= '0;
                fill    <= '0;
                count   <= '0;
                det     <= 1'b0;
            end else begin
                det <= accept && match;
                if (accept) begin
                    hist <= h_next;
                    fill <= (match && !overlap) ? 4'd0 : f_next;
                end
                // Clear wins over an increment landing on the same edge.
                if (bus.ui_in[7]) begin
                    count <= '0;
                end else if (accept && match) begin
                    count <= count + 4'd1;
                end
            end
        end
    end

    always_comb begin
        case (count)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
    end

    assign bus.uo_out  = {det, seg};
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_prog_seq_det.sv
// Directed bench for the programmable sequence detector; expected values are
// hand-computed from the pattern, length and overlap settings of each step.
module tb_tt_um_prog_seq_det;

    logic clk;
    logic rst_n;
    tt_um_prog_seq_det_if bus ();

    tt_um_prog_seq_det dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec;
    int nerr;

    logic       data;
    logic       strobe;
    logic       load;
    logic       ovl;
    logic [2:0] lenm1;
    logic       clr;
    logic       d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        bus.ui_in = {clr, lenm1, ovl, load, strobe, data};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe high for one edge, low for one edge; det is sampled after the accept edge.
    task automatic send_bit(input logic b, output logic det_seen);
        data   = b;
        strobe = 1'b1;
        drive();
        tick();
        det_seen = bus.uo_out[7];
        strobe   = 1'b0;
        drive();
        tick();
    endtask

    task automatic send_chk(input logic b, input logic exp_det, input string tag);
        logic dd;
        send_bit(b, dd);
        check(tag, {7'd0, dd}, {7'd0, exp_det});
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [2:0] lm1, input logic ov);
        bus.uio_in = pat;
        lenm1      = lm1;
        ovl        = ov;
        load       = 1'b1;
        drive();
        tick();
        load = 1'b0;
        drive();
        tick();
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        data       = 1'b0;
        strobe     = 1'b0;
        load       = 1'b0;
        ovl        = 1'b0;
        lenm1      = 3'd0;
        clr        = 1'b0;
        bus.ena    = 1'b1;
        bus.uio_in = 8'h00;
        drive();
        rst_n = 1'b0;

        // Reset
        tick();
        tick();
        check("reset_uo_out", bus.uo_out, 8'h3F);
        check("reset_uio_oe", bus.uio_oe, 8'h00);
        check("reset_uio_out", bus.uio_out, 8'h00);
        rst_n = 1'b1;
        tick();
        send_chk(1'b1, 1'b0, "rst_seq_b1");
        send_chk(1'b0, 1'b0, "rst_seq_b2");
        send_chk(1'b1, 1'b0, "rst_seq_b3");
        send_chk(1'b1, 1'b1, "rst_seq_b4_det");
        check("rst_seq_seg", {1'b0, bus.uo_out[6:0]}, 8'h06);
        check("det_one_cycle", {7'd0, bus.uo_out[7]}, 8'h00);

        // Overlap with default pattern: 1011011
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst2_uo_out", bus.uo_out, 8'h3F);
        send_chk(1'b1, 1'b0, "ov_b1");
        send_chk(1'b0, 1'b0, "ov_b2");
        send_chk(1'b1, 1'b0, "ov_b3");
        send_chk(1'b1, 1'b1, "ov_b4");
        send_chk(1'b0, 1'b0, "ov_b5");
        send_chk(1'b1, 1'b0, "ov_b6");
        send_chk(1'b1, 1'b1, "ov_b7");
        check("ov_count2", bus.uo_out, 8'h5B);

        // Same pattern loaded, non-overlap
        do_load(8'h0B, 3'd3, 1'b0);
        check("load_clears_count", bus.uo_out, 8'h3F);
        send_chk(1'b1, 1'b0, "nov_b1");
        send_chk(1'b0, 1'b0, "nov_b2");
        send_chk(1'b1, 1'b0, "nov_b3");
        send_chk(1'b1, 1'b1, "nov_b4");
        send_chk(1'b0, 1'b0, "nov_b5");
        send_chk(1'b1, 1'b0, "nov_b6");
        send_chk(1'b1, 1'b0, "nov_b7");
        check("nov_count1", bus.uo_out, 8'h06);

        // Length 3, pattern 111, overlap
        do_load(8'h07, 3'd2, 1'b1);
        send_chk(1'b1, 1'b0, "l3ov_b1");
        send_chk(1'b1, 1'b0, "l3ov_b2");
        send_chk(1'b1, 1'b1, "l3ov_b3");
        send_chk(1'b1, 1'b1, "l3ov_b4");
        send_chk(1'b1, 1'b1, "l3ov_b5");
        check("l3ov_count3", bus.uo_out, 8'h4F);

        // Length 3, pattern 111, non-overlap
        do_load(8'h07, 3'd2, 1'b0);
        send_chk(1'b1, 1'b0, "l3nov_b1");
        send_chk(1'b1, 1'b0, "l3nov_b2");
        send_chk(1'b1, 1'b1, "l3nov_b3");
        send_chk(1'b1, 1'b0, "l3nov_b4");
        send_chk(1'b1, 1'b0, "l3nov_b5");
        check("l3nov_count1", bus.uo_out, 8'h06);
        check("l3nov_partial_fill", {4'd0, dut.fill}, 8'h02);

        // Strobe held high accepts a single bit
        do_load(8'h0B, 3'd3, 1'b1);
        data   = 1'b1;
        strobe = 1'b1;
        drive();
        for (int i = 0; i < 10; i++) tick();
        check("held_fill1", {4'd0, dut.fill}, 8'h01);
        check("held_count0", bus.uo_out, 8'h3F);
        strobe = 1'b0;
        drive();
        tick();
        tick();
        // Strobe toggled every 2 cycles: bits 0,1,1 complete 1011
        data = 1'b0; strobe = 1'b1; drive(); tick(); tick();
        strobe = 1'b0; drive(); tick(); tick();
        data = 1'b1; strobe = 1'b1; drive(); tick(); tick();
        strobe = 1'b0; drive(); tick(); tick();
        data = 1'b1; strobe = 1'b1; drive(); tick();
        check("slow_det", {7'd0, bus.uo_out[7]}, 8'h01);
        tick();
        check("slow_det_gone", {7'd0, bus.uo_out[7]}, 8'h00);
        strobe = 1'b0; drive(); tick(); tick();
        check("slow_fill4", {4'd0, dut.fill}, 8'h04);
        check("slow_count1", bus.uo_out, 8'h06);

        // Count wrap with a 1-bit pattern
        do_load(8'h01, 3'd0, 1'b1);
        for (int i = 0; i < 15; i++) send_bit(1'b1, d);
        check("wrap_count15", bus.uo_out, 8'h71);
        send_chk(1'b1, 1'b1, "wrap_det16");
        check("wrap_count0", bus.uo_out, 8'h3F);
        send_chk(1'b1, 1'b1, "wrap_det17");
        check("wrap_count1", bus.uo_out, 8'h06);
        clr    = 1'b1;
        data   = 1'b1;
        strobe = 1'b1;
        drive();
        tick();
        check("clear_on_match", bus.uo_out, 8'hBF);
        clr    = 1'b0;
        strobe = 1'b0;
        drive();
        tick();
        check("clear_after", bus.uo_out, 8'h3F);

        // Mid-stream load discards history
        do_load(8'h0B, 3'd3, 1'b1);
        send_chk(1'b1, 1'b0, "ml_b1");
        send_chk(1'b0, 1'b0, "ml_b2");
        send_chk(1'b1, 1'b0, "ml_b3");
        load = 1'b1;
        drive();
        tick();
        load = 1'b0;
        drive();
        send_chk(1'b1, 1'b0, "ml_after_load");
        send_chk(1'b1, 1'b0, "ml_full_b1");
        send_chk(1'b0, 1'b0, "ml_full_b2");
        send_chk(1'b1, 1'b0, "ml_full_b3");
        send_chk(1'b1, 1'b1, "ml_full_b4");

        // Mid-stream reset discards history
        send_chk(1'b1, 1'b0, "mr_b1");
        send_chk(1'b0, 1'b0, "mr_b2");
        send_chk(1'b1, 1'b0, "mr_b3");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_reset_out", bus.uo_out, 8'h3F);
        send_chk(1'b1, 1'b0, "mr_after_rst");
        send_chk(1'b1, 1'b0, "mr_full_b1");
        send_chk(1'b0, 1'b0, "mr_full_b2");
        send_chk(1'b1, 1'b0, "mr_full_b3");
        send_chk(1'b1, 1'b1, "mr_full_b4");
        check("mr_count1", bus.uo_out, 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tt_um_prog_seq_det.md
# tt_um_prog_seq_det

Programmable serial sequence detector: the successor to the fixed-pattern 7-segment sequence detector, with a run-time loadable pattern of 1..MAX_LEN bits, selectable overlapping/non-overlapping matching, and a hex match counter on the 7-segment output. It sits as a standard Tiny Tapeout user macro. Serial bits are entered one per rising edge of a strobe pin. The pattern is loaded from the bidirectional pins, which are used as inputs only.

## Interface
- MAX_LEN, 8: pattern/history width, 1..8.
- RESET_PATTERN, 8'b0000_1011: pattern after reset; the low RESET_LEN bits are used.
- RESET_LEN, 4: pattern length after reset, 1..MAX_LEN.
- RESET_OVERLAP, 1: overlap mode after reset.
- clk  input  1  single design clock.
- rst_n  input  1  reset; synchronous, active-low.
- ena  input  1  ignored.
- ui_in  input  8  [0] serial data, [1] bit strobe, [2] load, [3] overlap select (latched during load), [6:4] length−1 (latched during load), [7] count clear.
- uio_in  input  8  pattern value, latched during load; the bit sampled last is compared against bit 0.
- uo_out  output  8  [6:0] segments a..g (bit0 = a), active-high hex digit of the count; [7] detect pulse.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all inputs).

## Operation
- Registers: pattern[MAX_LEN-1:0], len, overlap, hist[MAX_LEN-1:0], fill (0..MAX_LEN, saturating), count[3:0], det, strobe_q.
- Reset (rst_n = 0 at a clk edge):
  - pattern = RESET_PATTERN, len = RESET_LEN, overlap = RESET_OVERLAP.
  - hist, fill, count, det and strobe_q cleared.
  - uo_out = 8'h3F; uio_out = uio_oe = 0.
- Priority at each edge: reset > load > strobe/clear.
- Two states:
  - LOAD: while ui_in[2] = 1.
    - Every cycle: pattern ← uio_in, len ← min(ui_in[6:4]+1, MAX_LEN), overlap ← ui_in[3].
    - hist, fill, count ← 0; det ← 0; strobe edges ignored.
    - strobe_q still tracks ui_in[1].
  - DETECT: while ui_in[2] = 0.
- Accept event: ui_in[1] = 1 and strobe_q = 0 (rising edge of the strobe). A strobe held high accepts exactly one bit.
- On accept:
  - h' = {hist[MAX_LEN-2:0], ui_in[0]}; f' = min(fill+1, MAX_LEN).
  - match = (f' ≥ len) and (h' & mask(len)) == (pattern & mask(len)).
  - hist ← h'.
  - fill ← (match and not overlap) ? 0 : f'.
  - det ← match.
  - count ← count+1 (mod 16) on match.
- No accept: det ← 0; hist, fill and count held.
- Clear (ui_in[7] = 1, not in LOAD): count ← 0. Takes precedence over a simultaneous increment. hist, fill and det still update normally.
- 7-segment encoding, count 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

## Timing
- All outputs are registered, or decoded combinationally from registers only. There is no combinational path from input to output.
- A bit is sampled at the edge where the strobe rise is first seen. det is high for exactly one cycle, after that same edge. count and the segment display update at the same edge.
- Back-to-back accepts need strobe low for at least one sampled edge between them. The maximum rate is therefore one bit every 2 cycles.
- Leaving LOAD: the first accept can occur at the first edge with ui_in[2] = 0.
- A reset asserted mid-stream discards partial history; the next match needs a full len bits after reset.

## Test plan
- Reset: hold rst_n = 0 for 2 edges -> uo_out = 8'h3F, uio_oe = 8'h00; release; strobe bits 1,0,1,1 -> det pulses one cycle after the 4th bit, uo_out[6:0] = 06.
- Overlap, default pattern: stream 1011011 -> det after bits 4 and 7, count = 2 (5B). Repeat after a load with the same pattern (uio_in = 0x0B, [6:4] = 3) and overlap = 0 -> a single det, count = 1.
- Length 3, pattern 111: stream five 1s -> overlap gives 3 dets (count 3, 4F); non-overlap gives 1 det (after bit 3), then a 2-bit partial.
- Strobe held high 10 cycles with data 1 -> exactly one bit accepted (fill = 1); toggling strobe each 2 cycles accepts every bit.
- Count wrap and clear: 16 matches -> count 0, uo_out[6:0] = 3F; clear asserted on the edge of a match -> det = 1, count = 0.
- Mid-stream disruption: after bits 1,0,1, assert load or rst_n = 0 for 1 edge, then send 1 -> no det; a full 1011 afterwards -> det.
